fetch_seq: RTL and testbench

Parametrised program-sequencing front end for the core: owns the program counter, the jump lookup table, the registered ALU flags and the req/done handshake that starts and finishes a program. It generalises the current fetch path in three ways: configurable PC width, multiple selectable program entry points, and an explicit halt/stall-aware run state machine. It sits between the control decoder/ALU and the instruction ROM, which is addressed by `prog_ctr`.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_seq_if.sv | 42 ++++
 rtl/jump_lut.sv | 27 ++
 rtl/fetch_seq.sv | 134 +++++++++++++
 tb/tb_fetch_seq.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the program-sequencing front end.
// Holds the run-state enum, default geometry (D, P, LW) and the jump LUT contents.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fetch_state_t;

  localparam int DEF_D  = 12;
  localparam int DEF_P  = 4;
  localparam int DEF_LW = 5;

  // Jump targets / offsets. Entries are read as two's complement for relative
  // jumps, so 12'hFFE is -2.
  localparam logic [DEF_D-1:0] JUMP_LUT [0:(1<<DEF_LW)-1] = '{
    12'h000, 12'h3FE, 12'h100, 12'hFFE, 12'h010, 12'h805, 12'hC05, 12'h002,
    12'h004, 12'hFFC, 12'h200, 12'h300, 12'h400, 12'h500, 12'h600, 12'h700,
    12'h008, 12'hFF8, 12'h020, 12'hFE0, 12'h0F0, 12'h7FF, 12'hBFF, 12'hFFF,
    12'h001, 12'h003, 12'h005, 12'h007, 12'h009, 12'h00B, 12'h00D, 12'h00F
  };

endpackage

// File: rtl/fetch_seq_if.sv
// fetch_seq_if: decoder/ALU side bus of the fetch sequencer.
// Handshake: the master raises req (with prog_sel) while the sequencer is idle
// or done; the request is accepted on that clock edge and busy is high from the
// next cycle until the program ends, when done rises. req while busy is ignored.
// state exposes the run FSM for observation.
interface fetch_seq_if #(
  parameter int D  = fetch_pkg::DEF_D,
  parameter int P  = fetch_pkg::DEF_P,
  parameter int LW = fetch_pkg::DEF_LW
);
  logic                 req;
  logic [$clog2(P)-1:0] prog_sel;
  logic                 stall;
  logic                 halt;
  logic                 absjump_en;
  logic                 reljump_en;
  logic [LW-1:0]        lut_idx;
  logic                 sc_o;
  logic                 pari;
  logic                 zero;
  logic                 sc_clr;
  logic                 sc_en;
  logic [D-1:0]         prog_ctr;
  logic                 sc_q;
  logic                 pari_q;
  logic                 zero_q;
  logic                 busy;
  logic                 done;
  fetch_pkg::fetch_state_t state;

  modport master (
    output req, prog_sel, stall, halt, absjump_en, reljump_en, lut_idx,
           sc_o, pari, zero, sc_clr, sc_en,
    input  prog_ctr, sc_q, pari_q, zero_q, busy, done, state
  );

  modport slave (
    input  req, prog_sel, stall, halt, absjump_en, reljump_en, lut_idx,
           sc_o, pari, zero, sc_clr, sc_en,
    output prog_ctr, sc_q, pari_q, zero_q, busy, done, state
  );
endinterface

// File: rtl/jump_lut.sv
// jump_lut: read-only jump table with a combinational read.
// Entries beyond the packaged table read as zero; entries are sign-extended
// or truncated to D bits.
module jump_lut
  import fetch_pkg::*;
#(
  parameter int D  = DEF_D,
  parameter int LW = DEF_LW
) (
  input  logic [LW-1:0] lut_idx,
  output logic [D-1:0]  lut_data
);

  logic [D-1:0] lut_mem [0:(1<<LW)-1];

  // Build the constant table from the packaged contents.
  for (genvar i = 0; i < (1 << LW); i++) begin : g_ent
    if (i < (1 << DEF_LW)) begin : g_def
      assign lut_mem[i] = D'(signed'(JUMP_LUT[i]));
    end else begin : g_pad
      assign lut_mem[i] = '0;
    end
  end

  assign lut_data = lut_mem[lut_idx];

endmodule

// File: rtl/fetch_seq.sv
// fetch_seq: program counter, jump handling, registered ALU flags and the
// req/busy/done run FSM. Optional cycle counter enabled by
// FETCH_SEQ_CYCLE_CNT_EN.
module fetch_seq
  import fetch_pkg::*;
#(
  parameter int D  = DEF_D,
  parameter int P  = DEF_P,
  parameter int LW = DEF_LW
) (
  input  logic        clk,
  input  logic        reset,
`ifdef FETCH_SEQ_CYCLE_CNT_EN
  output logic [31:0] cycles,
`endif
  fetch_seq_if.slave  bus
);

  localparam int PSW = $clog2(P);

  fetch_state_t state_q, state_d;
  logic [D-1:0] pc_q, pc_d;
  logic [D-1:0] end_q, end_d;
  logic         sc_q, sc_d;
  logic         pari_q, pari_d;
  logic         zero_q, zero_d;
  logic         busy_q, done_q;
  logic [D-1:0] lut_data;
  logic [D-1:0] entry_addr;
  logic [D-1:0] entry_end;

  // Regions are equal power-of-two slices, so entry/end are just the program
  // number on top of all-zero / all-one low bits.
  assign entry_addr = {bus.prog_sel, {(D-PSW){1'b0}}};
  assign entry_end  = {bus.prog_sel, {(D-PSW){1'b1}}};

  jump_lut #(.D(D), .LW(LW)) u_lut (
    .lut_idx  (bus.lut_idx),
    .lut_data (lut_data)
  );

`ifdef FETCH_SEQ_CYCLE_CNT_EN
  logic [31:0] cycles_q, cycles_d;
`endif

  // Next-state, PC and flag selection.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    end_d   = end_q;
    sc_d    = sc_q;
    pari_d  = pari_q;
    zero_d  = zero_q;
`ifdef FETCH_SEQ_CYCLE_CNT_EN
    cycles_d = cycles_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (bus.req) begin
          state_d = RUN;
          pc_d    = entry_addr;
          end_d   = entry_end;
          sc_d    = 1'b0;
          pari_d  = 1'b0;
          zero_d  = 1'b0;
`ifdef FETCH_SEQ_CYCLE_CNT_EN
          cycles_d = '0;
`endif
        end
      end
      RUN: begin
`ifdef FETCH_SEQ_CYCLE_CNT_EN
        // Stalled cycles count too; saturate rather than wrap.
        if (cycles_q != '1) cycles_d = cycles_q + 32'd1;
`endif
        if (!bus.stall) begin
          pari_d = bus.pari;
          zero_d = bus.zero;
          if (bus.sc_clr)     sc_d = 1'b0;
          else if (bus.sc_en) sc_d = bus.sc_o;

          if (bus.halt)            state_d = DONE;
          else if (bus.absjump_en) pc_d    = lut_data;
          else if (bus.reljump_en) pc_d    = pc_q + lut_data;
          else if (pc_q == end_q)  state_d = DONE;
          else                     pc_d    = pc_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, PC, flags and registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      end_q   <= '0;
      sc_q    <= 1'b0;
      pari_q  <= 1'b0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      end_q   <= end_d;
      sc_q    <= sc_d;
      pari_q  <= pari_d;
      zero_q  <= zero_d;
      busy_q  <= (state_d == RUN);
      done_q  <= (state_d == DONE);
    end
  end

`ifdef FETCH_SEQ_CYCLE_CNT_EN
  // Run-length counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cycles_q <= '0;
    else        cycles_q <= cycles_d;
  end

  assign cycles = cycles_q;
`endif

  assign bus.prog_ctr = pc_q;
  assign bus.sc_q     = sc_q;
  assign bus.pari_q   = pari_q;
  assign bus.zero_q   = zero_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_fetch_seq.sv
// tb_fetch_seq: directed stimulus against an abstract reference model of the
// fetch sequencer, compared every cycle, plus hand-computed literal checks.
module tb_fetch_seq;
  localparam int D  = 12;
  localparam int P  = 4;
  localparam int LW = 5;
  localparam int R  = (1 << D) / P;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  fetch_seq_if #(.D(D), .P(P), .LW(LW)) bus ();

`ifdef FETCH_SEQ_CYCLE_CNT_EN
  logic [31:0] cycles;
`endif

  fetch_seq #(.D(D), .P(P), .LW(LW)) dut (
    .clk    (clk),
    .reset  (reset),
`ifdef FETCH_SEQ_CYCLE_CNT_EN
    .cycles (cycles),
`endif
    .bus    (bus)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Reference model: mode 0 idle, 1 running, 2 finished.
  int          m_mode   = 0;
  int unsigned m_pc     = 0;
  int unsigned m_end    = 0;
  bit          m_sc     = 0;
  bit          m_pari   = 0;
  bit          m_zero   = 0;
  longint      m_cycles = 0;

  function automatic int unsigned tb_lut(input int idx);
    case (idx)
      1:       return 32'h3FE;
      2:       return 32'h100;
      3:       return 32'hFFE;
      4:       return 32'h010;
      default: return 32'h000;
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode = 0; m_pc = 0; m_end = 0;
      m_sc = 0; m_pari = 0; m_zero = 0; m_cycles = 0;
    end else if (m_mode == 1) begin
      if (m_cycles < 64'hFFFF_FFFF) m_cycles = m_cycles + 1;
      if (!bus.stall) begin
        m_pari = bus.pari;
        m_zero = bus.zero;
        if (bus.sc_clr)     m_sc = 0;
        else if (bus.sc_en) m_sc = bus.sc_o;
        if (bus.halt)            m_mode = 2;
        else if (bus.absjump_en) m_pc = tb_lut(int'(bus.lut_idx));
        else if (bus.reljump_en) m_pc = (m_pc + tb_lut(int'(bus.lut_idx))) % (1 << D);
        else if (m_pc == m_end)  m_mode = 2;
        else                     m_pc = m_pc + 1;
      end
    end else if (bus.req) begin
      m_mode   = 1;
      m_pc     = int'(bus.prog_sel) * R;
      m_end    = m_pc + R - 1;
      m_sc     = 0; m_pari = 0; m_zero = 0;
      m_cycles = 0;
    end
  end

  // Scoreboard check shared by the compare process and the literal checks.
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("cyc_prog_ctr", 32'(bus.prog_ctr), m_pc);
    chk("cyc_busy", 32'(bus.busy), 32'(m_mode == 1));
    chk("cyc_done", 32'(bus.done), 32'(m_mode == 2));
    chk("cyc_sc_q", 32'(bus.sc_q), 32'(m_sc));
    chk("cyc_pari_q", 32'(bus.pari_q), 32'(m_pari));
    chk("cyc_zero_q", 32'(bus.zero_q), 32'(m_zero));
`ifdef FETCH_SEQ_CYCLE_CNT_EN
    chk("cyc_cycles", cycles, 32'(m_cycles));
`endif
  end

  // Driver tasks
  task automatic clear_inputs();
    bus.req = 0; bus.prog_sel = '0; bus.stall = 0; bus.halt = 0;
    bus.absjump_en = 0; bus.reljump_en = 0; bus.lut_idx = '0;
    bus.sc_o = 0; bus.pari = 0; bus.zero = 0; bus.sc_clr = 0; bus.sc_en = 0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic start(input int sel);
    bus.req = 1; bus.prog_sel = 2'(sel);
    step(1);
    bus.req = 0;
  endtask

  initial begin
    clear_inputs();
    #1 reset = 0;
    step(2);
    chk("rst_pc", 32'(bus.prog_ctr), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_done", 32'(bus.done), 32'h0);
    reset = 1;
    step(1);
    chk("idle_busy", 32'(bus.busy), 32'h0);

    // Start program 2, sequential advance with flag updates.
    start(2);
    chk("start2_pc", 32'(bus.prog_ctr), 32'h800);
    chk("start2_busy", 32'(bus.busy), 32'h1);
    bus.pari = 1; bus.sc_en = 1; bus.sc_o = 1;
    step(3);
    chk("seq3_pc", 32'(bus.prog_ctr), 32'h803);
    chk("seq3_sc", 32'(bus.sc_q), 32'h1);
    bus.pari = 0; bus.zero = 1; bus.sc_en = 1; bus.sc_clr = 1;
    step(2);
    chk("seq5_pc", 32'(bus.prog_ctr), 32'h805);
    chk("sc_clr_wins", 32'(bus.sc_q), 32'h0);
    bus.sc_clr = 0; bus.sc_en = 0; bus.zero = 0;

    // Relative jump by -2, then absjump beats reljump.
    bus.reljump_en = 1; bus.lut_idx = 5'd3;
    step(1);
    chk("rel_pc", 32'(bus.prog_ctr), 32'h803);
    bus.absjump_en = 1; bus.lut_idx = 5'd4;
    step(1);
    chk("abs_wins_pc", 32'(bus.prog_ctr), 32'h010);
    bus.absjump_en = 0; bus.reljump_en = 0;
    bus.halt = 1;
    step(1);
    bus.halt = 0;
    chk("halt_done", 32'(bus.done), 32'h1);
    chk("halt_busy", 32'(bus.busy), 32'h0);
    step(2);
    chk("done_hold_pc", 32'(bus.prog_ctr), 32'h010);

    // Region overflow in program 0, req held through DONE restarts at once.
    start(0);
    chk("start0_pc", 32'(bus.prog_ctr), 32'h000);
    bus.absjump_en = 1; bus.lut_idx = 5'd1;
    step(1);
    bus.absjump_en = 0;
    chk("abs3fe_pc", 32'(bus.prog_ctr), 32'h3FE);
    bus.req = 1; bus.prog_sel = 2'd1;
    step(1);
    chk("req_in_run_pc", 32'(bus.prog_ctr), 32'h3FF);
    chk("req_in_run_busy", 32'(bus.busy), 32'h1);
    step(1);
    chk("ovf_pc", 32'(bus.prog_ctr), 32'h3FF);
    chk("ovf_done", 32'(bus.done), 32'h1);
    step(1);
    bus.req = 0;
    chk("restart_pc", 32'(bus.prog_ctr), 32'h400);
    chk("restart_done", 32'(bus.done), 32'h0);

    // Stall with halt and sc_en pending at 0x100.
    bus.absjump_en = 1; bus.lut_idx = 5'd2;
    step(1);
    bus.absjump_en = 0;
    chk("abs100_pc", 32'(bus.prog_ctr), 32'h100);
    bus.stall = 1; bus.halt = 1; bus.sc_en = 1; bus.sc_o = 1; bus.pari = 1;
    step(3);
    chk("stall_pc", 32'(bus.prog_ctr), 32'h100);
    chk("stall_busy", 32'(bus.busy), 32'h1);
    chk("stall_sc", 32'(bus.sc_q), 32'h0);
    bus.stall = 0;
    step(1);
    chk("unstall_done", 32'(bus.done), 32'h1);
    chk("unstall_sc", 32'(bus.sc_q), 32'h1);
    bus.halt = 0; bus.sc_en = 0; bus.sc_o = 0; bus.pari = 0;

    // Halt at 0xC05, restart from DONE into program 1, then reset mid-run.
    start(3);
    chk("start3_pc", 32'(bus.prog_ctr), 32'hC00);
    chk("start3_flags", 32'({bus.sc_q, bus.pari_q, bus.zero_q}), 32'h0);
    step(5);
    chk("c05_pc", 32'(bus.prog_ctr), 32'hC05);
    bus.halt = 1; bus.zero = 1; bus.pari = 1;
    step(1);
    bus.halt = 0; bus.zero = 0; bus.pari = 0;
    chk("c05_done", 32'(bus.done), 32'h1);
    chk("c05_zero", 32'(bus.zero_q), 32'h1);
    start(1);
    chk("from_done_pc", 32'(bus.prog_ctr), 32'h400);
    chk("from_done_done", 32'(bus.done), 32'h0);
    chk("from_done_flags", 32'({bus.sc_q, bus.pari_q, bus.zero_q}), 32'h0);
    step(2);
    reset = 0;
    #1;
    chk("arst_pc", 32'(bus.prog_ctr), 32'h0);
    chk("arst_busy", 32'(bus.busy), 32'h0);
    chk("arst_done", 32'(bus.done), 32'h0);
    @(posedge clk);
    #2 reset = 1;
    step(2);
    chk("post_rst_idle", 32'(bus.busy), 32'h0);

    // Five RUN cycles including two stalls.
    start(0);
    step(1);
    bus.stall = 1;
    step(2);
    bus.stall = 0;
    step(1);
    bus.halt = 1;
    step(1);
    bus.halt = 0;
    chk("cnt_run_pc", 32'(bus.prog_ctr), 32'h002);
`ifdef FETCH_SEQ_CYCLE_CNT_EN
    chk("cnt_done", cycles, 32'd5);
    step(1);
    chk("cnt_hold", cycles, 32'd5);
    start(2);
    chk("cnt_clear", cycles, 32'd0);
`else
    step(1);
    start(2);
`endif
    chk("last_pc", 32'(bus.prog_ctr), 32'h800);
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
